// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: access-size encodings,
// default memory window, FSM state and requester port identifiers.
package mem_pkg;

   localparam logic [1:0] ACC_BYTE = 2'd0;
   localparam logic [1:0] ACC_HALF = 2'd1;
   localparam logic [1:0] ACC_WORD = 2'd2;

   localparam logic [31:0] DEF_MEM_BASE = 32'h8002_0000;
   localparam logic [31:0] DEF_MEM_SIZE = 32'h0010_0000;

   typedef enum logic {BOOT, RUN} state_e;

   typedef enum logic {PORT_IF, PORT_DM} port_e;

   // Response tag captured at the grant edge; rd = 0 marks a rejected write.
   typedef struct packed {
      logic  vld;
      port_e port;
      logic  err;
      logic  rd;
   } tag_t;

endpackage

// File: rtl/addr_range_check.sv
// Combinational window check.
//   addr_i     : byte address under test
//   in_range_o : 1 when BASE <= addr_i < BASE + SIZE
module addr_range_check
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE = DEF_MEM_BASE,
   parameter logic [31:0] SIZE = DEF_MEM_SIZE
) (
   input  logic [31:0] addr_i,
   output logic        in_range_o
);

   logic [31:0] offset;

   // Offset compare avoids overflow of BASE + SIZE at the top of the space.
   assign offset     = addr_i - BASE;
   assign in_range_o = (addr_i >= BASE) && (offset < SIZE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory between the boot loader (BOOT phase
// only), instruction fetch and the data stage (RUN phase, dm over if).
//   ld_*      : loader write request / grant
//   boot_done : ends the BOOT phase
//   if_*      : fetch word read request, grant and response
//   dm_*      : data-stage request, grant and response
//   address, data_in, write, access_size, data_out : memory side
//   boot_busy : high while in BOOT
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter logic [31:0] MEM_BASE = DEF_MEM_BASE,
   parameter logic [31:0] MEM_SIZE = DEF_MEM_SIZE
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_wdata,
   input  logic [1:0]  ld_size,
   output logic        ld_gnt,
   input  logic        boot_done,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_write,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [1:0]  dm_size,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic        dm_err,
   output logic [31:0] dm_rdata,
   output logic [31:0] address,
   output logic [31:0] data_in,
   output logic        write,
   output logic [1:0]  access_size,
   input  logic [31:0] data_out,
   output logic        boot_busy
);

   state_e      state_q, state_d;
   tag_t        tag_q, tag_d;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;

   logic        granted;
   logic        sel_wr;
   logic [31:0] sel_addr, sel_wdata;
   logic [1:0]  sel_size;
   logic        in_range;

   addr_range_check #(
      .BASE (MEM_BASE),
      .SIZE (MEM_SIZE)
   ) u_range (
      .addr_i     (sel_addr),
      .in_range_o (in_range)
   );

   always_comb begin
      state_d   = state_q;
      ld_gnt    = 1'b0;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      granted   = 1'b0;
      sel_wr    = 1'b0;
      sel_addr  = ld_addr;
      sel_wdata = ld_wdata;
      sel_size  = ld_size;
      unique case (state_q)
         BOOT: begin
            ld_gnt  = ld_req;
            granted = ld_req;
            sel_wr  = ld_req;
            if (boot_done) state_d = RUN;
         end
         RUN: begin
            if (dm_req) begin
               dm_gnt    = 1'b1;
               granted   = 1'b1;
               sel_wr    = dm_write;
               sel_addr  = dm_addr;
               sel_wdata = dm_wdata;
               sel_size  = dm_size;
            end else if (if_req) begin
               if_gnt    = 1'b1;
               granted   = 1'b1;
               sel_addr  = if_addr;
               sel_wdata = wdata_q;
               sel_size  = ACC_WORD;
            end
         end
      endcase
   end

   // Out-of-window accesses are granted but never reach memory as writes.
   assign write       = sel_wr & in_range;
   assign address     = granted ? sel_addr  : addr_q;
   assign data_in     = granted ? sel_wdata : wdata_q;
   assign access_size = granted ? sel_size  : size_q;
   assign boot_busy   = (state_q == BOOT);

   // Tag every RUN grant that produces a response: reads, and rejected writes.
   always_comb begin
      tag_d      = '0;
      tag_d.vld  = if_gnt | (dm_gnt & (~dm_write | ~in_range));
      tag_d.port = dm_gnt ? PORT_DM : PORT_IF;
      tag_d.err  = ~in_range;
      tag_d.rd   = if_gnt | (dm_gnt & ~dm_write);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BOOT;
         tag_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         if (granted) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            size_q  <= sel_size;
         end
      end
   end

   assign if_rvalid = tag_q.vld & (tag_q.port == PORT_IF);
   assign if_err    = if_rvalid & tag_q.err;
   assign if_rdata  = (if_rvalid & ~tag_q.err) ? data_out : '0;

   assign dm_rvalid = tag_q.vld & (tag_q.port == PORT_DM) & tag_q.rd;
   assign dm_err    = tag_q.vld & (tag_q.port == PORT_DM) & tag_q.err;
   assign dm_rdata  = (dm_rvalid & ~tag_q.err) ? data_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ld_req, boot_done, if_req, dm_req, dm_write;
   logic [31:0] ld_addr, ld_wdata, if_addr, dm_addr, dm_wdata;
   logic [1:0]  ld_size, dm_size;
   logic        ld_gnt, if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err;
   logic [31:0] if_rdata, dm_rdata, address, data_in, data_out;
   logic        write, boot_busy;
   logic [1:0]  access_size;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ld_req      (ld_req),
      .ld_addr     (ld_addr),
      .ld_wdata    (ld_wdata),
      .ld_size     (ld_size),
      .ld_gnt      (ld_gnt),
      .boot_done   (boot_done),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_gnt      (if_gnt),
      .if_rvalid   (if_rvalid),
      .if_err      (if_err),
      .if_rdata    (if_rdata),
      .dm_req      (dm_req),
      .dm_write    (dm_write),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_size     (dm_size),
      .dm_gnt      (dm_gnt),
      .dm_rvalid   (dm_rvalid),
      .dm_err      (dm_err),
      .dm_rdata    (dm_rdata),
      .address     (address),
      .data_in     (data_in),
      .write       (write),
      .access_size (access_size),
      .data_out    (data_out),
      .boot_busy   (boot_busy)
   );

   // envm: memory as written by the DUT; refm: memory as the model expects it.
   bit [7:0] envm [bit [31:0]];
   bit [7:0] refm [bit [31:0]];

   function automatic bit [7:0] eb(input bit [31:0] a);
      if (envm.exists(a)) return envm[a];
      return 8'h00;
   endfunction

   function automatic bit [7:0] rb(input bit [31:0] a);
      if (refm.exists(a)) return refm[a];
      return 8'h00;
   endfunction

   function automatic bit [31:0] ew(input bit [31:0] a);
      return {eb(a + 3), eb(a + 2), eb(a + 1), eb(a)};
   endfunction

   function automatic bit [31:0] rw(input bit [31:0] a);
      return {rb(a + 3), rb(a + 2), rb(a + 1), rb(a)};
   endfunction

   function automatic int nbytes(input bit [1:0] s);
      if (s == ACC_WORD) return 4;
      if (s == ACC_HALF) return 2;
      return 1;
   endfunction

   function automatic bit in_win(input bit [31:0] a);
      return (a >= 32'h8002_0000) && (a <= 32'h8011_FFFF);
   endfunction

   // Synchronous-read memory: data_out shows the word addressed in the previous cycle.
   initial begin
      bit [31:0] rv;
      data_out = '0;
      forever begin
         @(posedge clk);
         rv = ew(address);
         if (write === 1'b1) begin
            for (int i = 0; i < nbytes(access_size); i++) envm[address + i] = data_in[8*i +: 8];
         end
         data_out = rv;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: boot flag, last driven bus values and a queue of responses.
   typedef struct {
      int        due;
      bit        dm;
      bit        err;
      bit        rd;
      bit [31:0] data;
   } resp_t;

   resp_t q[$];

   initial begin
      int        cyc;
      bit        m_boot, e_ld, e_if, e_dm, e_wr, g, inw;
      bit [31:0] la, ldv, ga, gd;
      bit [1:0]  ls, gs;
      bit        xv_if, xe_if, xv_dm, xe_dm;
      bit [31:0] xd;
      resp_t     r;
      cyc = 0; m_boot = 1; la = 0; ldv = 0; ls = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            m_boot = 1; la = 0; ldv = 0; ls = 0;
            q.delete();
            chk("rst_ld_gnt", ld_gnt, 0);
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_dm_gnt", dm_gnt, 0);
            chk("rst_write", write, 0);
            chk("rst_address", address, 0);
            chk("rst_data_in", data_in, 0);
            chk("rst_access_size", access_size, 0);
            chk("rst_boot_busy", boot_busy, 1);
            chk("rst_resp", {if_rvalid, if_err, dm_rvalid, dm_err}, 0);
         end else begin
            e_ld = 0; e_if = 0; e_dm = 0; e_wr = 0; g = 0;
            ga = la; gd = ldv; gs = ls;
            if (m_boot) begin
               if (ld_req) begin
                  e_ld = 1; g = 1; ga = ld_addr; gd = ld_wdata; gs = ld_size;
                  e_wr = in_win(ga);
               end
            end else if (dm_req) begin
               e_dm = 1; g = 1; ga = dm_addr; gd = dm_wdata; gs = dm_size;
               e_wr = dm_write && in_win(ga);
            end else if (if_req) begin
               e_if = 1; g = 1; ga = if_addr; gs = ACC_WORD;
            end
            inw = in_win(ga);

            xv_if = 0; xe_if = 0; xv_dm = 0; xe_dm = 0; xd = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
               r = q.pop_front();
               xd = r.data;
               if (r.dm) begin
                  xv_dm = r.rd; xe_dm = r.err;
               end else begin
                  xv_if = 1; xe_if = r.err;
               end
            end

            chk("ld_gnt", ld_gnt, e_ld);
            chk("if_gnt", if_gnt, e_if);
            chk("dm_gnt", dm_gnt, e_dm);
            chk("write", write, e_wr);
            chk("boot_busy", boot_busy, m_boot);
            chk("address", address, ga);
            chk("data_in", data_in, gd);
            chk("access_size", access_size, gs);
            chk("if_rvalid", if_rvalid, xv_if);
            chk("if_err", if_err, xe_if);
            chk("dm_rvalid", dm_rvalid, xv_dm);
            chk("dm_err", dm_err, xe_dm);
            if (xv_if) chk("if_rdata", if_rdata, xd);
            if (xv_dm) chk("dm_rdata", dm_rdata, xd);

            if (e_if) q.push_back('{cyc + 1, 1'b0, !inw, 1'b1, inw ? rw(ga) : 32'h0});
            if (e_dm && (!dm_write || !inw))
               q.push_back('{cyc + 1, 1'b1, !inw, !dm_write, (inw && !dm_write) ? rw(ga) : 32'h0});
            if (e_wr) begin
               for (int i = 0; i < nbytes(gs); i++) refm[ga + i] = gd[8*i +: 8];
            end
            if (g) begin
               la = ga; ldv = gd; ls = gs;
            end
            if (m_boot && boot_done) m_boot = 0;
         end
         cyc++;
      end
   end

   task automatic set(input logic l, input logic [31:0] la, input logic [31:0] lw,
                      input logic [1:0] ls, input logic bd, input logic ir,
                      input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd, input logic [1:0] ds);
      ld_req = l; ld_addr = la; ld_wdata = lw; ld_size = ls; boot_done = bd;
      if_req = ir; if_addr = ia;
      dm_req = dr; dm_write = dw; dm_addr = da; dm_wdata = dd; dm_size = ds;
   endtask

   task automatic idle();
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 0, 0, 0, 0, ACC_BYTE);
   endtask

   task automatic go();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      idle();
      go();
      chk("L_rst_boot_busy", boot_busy, 1);
      chk("L_rst_address", address, 0);
      adv();
      reset_n = 1'b1;

      // Boot: loader writes while fetch is requesting.
      set(1, 32'h8002_0000, 32'h0000_00A5, ACC_BYTE, 0, 1, 32'h8002_0000, 0, 0, 0, 0, ACC_WORD);
      go();
      chk("L_boot_ld_gnt", ld_gnt, 1);
      chk("L_boot_if_gnt", if_gnt, 0);
      chk("L_boot_write", write, 1);
      adv();
      set(1, 32'h8002_0004, 32'h1122_3344, ACC_WORD, 0, 1, 32'h8002_0000, 0, 0, 0, 0, ACC_WORD);
      go(); adv();
      set(1, 32'h8002_0008, 32'hCAFE_F00D, ACC_WORD, 0, 0, 0, 0, 0, 0, 0, ACC_WORD);
      go(); adv();
      // boot_done coincident with a loader write and a fetch request.
      set(1, 32'h8002_000C, 32'h5566_7788, ACC_WORD, 1, 1, 32'h8002_0000, 0, 0, 0, 0, ACC_WORD);
      go();
      chk("L_bd_ld_gnt", ld_gnt, 1);
      chk("L_bd_write", write, 1);
      adv();
      set(1, 32'h8002_000C, 32'h0, ACC_WORD, 0, 1, 32'h8002_0000, 0, 0, 0, 0, ACC_WORD);
      go();
      chk("L_run_ld_gnt", ld_gnt, 0);
      chk("L_run_if_gnt", if_gnt, 1);
      chk("L_run_boot_busy", boot_busy, 0);
      adv();
      set(1, 32'h8002_000C, 32'h0, ACC_WORD, 0, 0, 0, 1, 0, 32'h8002_000C, 0, ACC_WORD);
      go();
      chk("L_fetch_rvalid", if_rvalid, 1);
      chk("L_fetch_A5", if_rdata, 32'h0000_00A5);
      chk("L_ld_ignored", ld_gnt, 0);
      adv();

      // Simultaneous dm and if requests.
      set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0008, 1, 0, 32'h8002_0004, 0, ACC_WORD);
      go();
      chk("L_bd_write_landed", dm_rdata, 32'h5566_7788);
      chk("L_prio_dm", dm_gnt, 1);
      chk("L_prio_if", if_gnt, 0);
      adv();
      set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0008, 0, 0, 0, 0, ACC_WORD);
      go();
      chk("L_if_second", if_gnt, 1);
      chk("L_dm_resp", dm_rdata, 32'h1122_3344);
      adv();
      idle();
      go();
      chk("L_if_resp", if_rdata, 32'hCAFE_F00D);
      chk("L_if_resp_dm_quiet", dm_rvalid, 0);
      adv();

      // Out-of-range write is granted but rejected.
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, ACC_WORD);
      go();
      chk("L_oor_gnt", dm_gnt, 1);
      chk("L_oor_write", write, 0);
      adv();
      idle();
      go();
      chk("L_oor_err", dm_err, 1);
      chk("L_oor_no_rvalid", dm_rvalid, 0);
      adv();
      go();
      chk("L_oor_err_pulse", dm_err, 0);
      chk("L_oor_mem", ew(32'h0000_0010), 0);
      adv();

      // Window edges.
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 1, 32'h8011_FFFC, 32'h600D_F00D, ACC_WORD);
      go(); chk("L_top_write", write, 1); adv();
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 0, 32'h7FFF_FFFC, 0, ACC_WORD);
      go(); adv();
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 0, 32'h8011_FFFC, 0, ACC_WORD);
      go(); chk("L_below_err", dm_err, 1); chk("L_below_data", dm_rdata, 0); adv();
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 0, 32'h8012_0000, 0, ACC_WORD);
      go(); chk("L_top_err", dm_err, 0); chk("L_top_data", dm_rdata, 32'h600D_F00D); adv();
      idle();
      go(); chk("L_above_err", dm_err, 1); chk("L_above_rvalid", dm_rvalid, 1); adv();

      // Fetch read followed directly by a data write.
      set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0004, 0, 0, 0, 0, ACC_WORD);
      go(); adv();
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 1, 32'h8002_0010, 32'h0BAD_C0DE, ACC_WORD);
      go();
      chk("L_b2b_write", write, 1);
      chk("L_b2b_if_rvalid", if_rvalid, 1);
      chk("L_b2b_if_rdata", if_rdata, 32'h1122_3344);
      chk("L_b2b_dm_rvalid", dm_rvalid, 0);
      adv();
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 1, 32'h8002_0012, 32'h0000_BEEF, ACC_HALF);
      go(); chk("L_half_size", access_size, ACC_HALF); adv();
      set(0, 0, 0, ACC_BYTE, 0, 0, 0, 1, 1, 32'h8002_0010, 32'h0000_0077, ACC_BYTE);
      go(); adv();
      set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0010, 0, 0, 0, 0, ACC_WORD);
      go(); adv();
      idle();
      go(); chk("L_merge", if_rdata, 32'hBEEF_C077); adv();

      // Reset right after a read grant drops the response.
      set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0004, 0, 0, 0, 0, ACC_WORD);
      go(); chk("L_pre_rst_gnt", if_gnt, 1); adv();
      reset_n = 1'b0;
      idle();
      go();
      chk("L_mid_rst_rvalid", if_rvalid, 0);
      chk("L_mid_rst_busy", boot_busy, 1);
      adv();
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0000, 1, 0, 32'h8002_0000, 0, ACC_WORD);
         go();
         chk("L_post_rst_gnt", {if_gnt, dm_gnt}, 0);
         chk("L_post_rst_rvalid", if_rvalid, 0);
         adv();
      end
      set(0, 0, 0, ACC_BYTE, 1, 1, 32'h8002_0000, 1, 0, 32'h8002_0000, 0, ACC_WORD);
      go(); chk("L_bd_cycle_gnt", dm_gnt, 0); adv();
      set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0000, 1, 0, 32'h8002_0000, 0, ACC_WORD);
      go(); chk("L_first_run_gnt", dm_gnt, 1); adv();
      set(0, 0, 0, ACC_BYTE, 0, 1, 32'h8002_0000, 0, 0, 0, 0, ACC_WORD);
      go(); chk("L_final_dm", dm_rdata, 32'h0000_00A5); adv();
      idle();
      go(); chk("L_final_if", if_rdata, 32'h0000_00A5); adv();

      // Memory image written by the DUT must match the model's.
      chk("mem_img_count", envm.num(), refm.num());
      foreach (refm[k]) chk("mem_img", {24'h0, eb(k)}, {24'h0, refm[k]});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported `memory` between three requesters: the SREC loader (boot-time byte writes), instruction fetch (word reads), and the data/memory stage (reads and writes of any access size). The block sequences a boot phase, in which only the loader may write, followed by a run phase with fixed-priority, one-access-per-cycle arbitration. It range-checks addresses against the mapped window and returns read data to the requester that issued the read.

## Interface
- `MEM_BASE`, 32'h80020000, first byte address mapped to memory.
- `MEM_SIZE`, 32'h00100000, bytes mapped; valid window is `[MEM_BASE, MEM_BASE+MEM_SIZE)`.
- `clk` in 1: single clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ld_req`, `ld_addr[31:0]`, `ld_wdata[31:0]`, `ld_size[1:0]` in: loader write request.
- `ld_gnt` out 1: loader write accepted this cycle.
- `boot_done` in 1: loader finished; sampled in BOOT only.
- `if_req`, `if_addr[31:0]` in: fetch word read request.
- `if_gnt` out 1: fetch request accepted.
- `if_rvalid`, `if_err` out 1; `if_rdata[31:0]` out: fetch read response.
- `dm_req`, `dm_write`, `dm_addr[31:0]`, `dm_wdata[31:0]`, `dm_size[1:0]` in: data-stage request.
- `dm_gnt` out 1: data request accepted.
- `dm_rvalid`, `dm_err` out 1; `dm_rdata[31:0]` out: data read response. `dm_err` also pulses for rejected writes.
- `address[31:0]`, `data_in[31:0]`, `write` out, `access_size[1:0]` out: to `memory`.
- `data_out[31:0]` in: from `memory`.
- `boot_busy` out 1: high in BOOT.

## Operation
- States: BOOT, RUN. Reset enters BOOT.
- BOOT:
  - `ld_gnt = ld_req`; `if_gnt` and `dm_gnt` held 0.
  - `boot_done` high at a rising edge moves the block to RUN. If `ld_req` is high in the same cycle, that write still completes.
- RUN:
  - Loader is ignored; `ld_gnt` = 0.
  - Priority is dm over if. At most one grant per cycle; the losing requester holds its request.
- Granted access drives `address`, `data_in`, `access_size` and `write` from the winner in the same cycle.
  - `access_size` is forwarded unchanged; fetch always drives the word encoding from the shared package.
  - No grant: `write` = 0, `address`/`data_in` hold their last value.
- Range check: an address outside the window is still granted, but `write` is forced to 0 and the response has err = 1 and rdata = 0.
  - A rejected write produces a one-cycle `dm_err` pulse without `dm_rvalid`.
- Reads: a registered tag {port, err} is captured at the grant edge.

## Timing
- Grants are combinational from req and state (same cycle). Writes commit at the rising edge ending the grant cycle.
- Read latency is 1: `*_rvalid` is high in the cycle after the grant, and `*_rdata = data_out` passthrough in that cycle.
  - Back-to-back reads are fully pipelined: throughput is one access per cycle.
- A write granted in the cycle after a read does not disturb the read response. The response uses the tag, not the current grant.
- Reset values (async, applied immediately): all gnt/rvalid/err = 0, `write` = 0, `address` = 0, `data_in` = 0, `access_size` = 0, `boot_busy` = 1, tag cleared.
- Reset asserted mid-read: the pending response is dropped and no rvalid is issued after release.
- `boot_done` while `if_req`/`dm_req` are high: the first grant is issued in the first RUN cycle.

## Structure
- Shared package `mem_pkg`:
  - access_size encodings: `ACC_WORD`, `ACC_HALF`, `ACC_BYTE`.
  - `MEM_BASE`/`MEM_SIZE` defaults.
  - State enum {BOOT, RUN}.
  - Port-id enum {PORT_IF, PORT_DM}.
- One natural sub-module: `addr_range_check` (combinational, returns in-window flag).
- Tag register and FSM stay in the top.

## Test plan
- Boot phase: loader writes 8'hA5 to 0x80020000 while `if_req` is high. Required: `ld_gnt` = 1, `if_gnt` = 0, `write` = 1. After RUN, a fetch of 0x80020000 returns byte A5 in the low byte of `if_rdata` with `if_rvalid` one cycle after `if_gnt`.
- Simultaneous `dm_req` read of 0x80020004 and `if_req` of 0x80020008 in RUN. Required: `dm_gnt` first, then `if_gnt` next cycle. Responses arrive on consecutive cycles, each on the correct port.
- Out-of-range `dm_write` to 0x00000010. Required: `dm_gnt` = 1, `write` = 0, `dm_err` pulses 1 cycle, memory unchanged.
- Fetch read then `dm_write` back-to-back. Required: `if_rvalid` = 1 with correct data on the cycle of the write grant, and no `dm_rvalid`.
- `reset_n` pulsed low in the cycle after a read grant. Required: `if_rvalid` never asserts, `boot_busy` = 1, and all grants are 0 until `boot_done`.
- `boot_done` coincident with a loader write. Required: the write lands, and `ld_gnt` = 0 in all subsequent cycles despite `ld_req` = 1.
